seq_pattern_tx: RTL and testbench

- Serial frame transmitter; the transmit-side counterpart of the team's Moore sequence detectors.
- Accepts a parallel data word over a valid/ready handshake.
- Emits a serial frame: a fixed sync preamble (default 1011), then the data word MSB-first, then a forced-zero guard gap.
- Its serial output drives the x input of a 1011 detector. The preamble arms the detector; the guard gap separates frames for non-overlapping detection.

---
 rtl/seq_pattern_tx.sv | 141 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync preamble, MSB-first payload, then a forced-zero guard gap.
// Its sdo output is meant to feed the x input of a 1011 sequence detector.
module seq_pattern_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               DATA_W  = 8,
  parameter int               GAP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sdo,
  output logic              sdo_en,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_cnt
);

  localparam int MAX_W = (PAT_W > DATA_W) ? ((PAT_W > GAP) ? PAT_W : GAP)
                                          : ((DATA_W > GAP) ? DATA_W : GAP);
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               sdo_q, sdo_d;
  logic               sdo_en_q, sdo_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [PAT_W-1:0]   pat_shift_s;

  // Next-state logic plus decode of the outputs for the coming cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          cnt_d   = CNT_W'(PAT_W - 1);
          state_d = ST_PRE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        shift_d = shift_q << 1;
        if (cnt_q == {CNT_W{1'b0}}) begin
          cnt_d       = CNT_W'(GAP - 1);
          state_d     = ST_GAP;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        shift_d = {DATA_W{1'b0}};
      end
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    pat_shift_s = PATTERN >> cnt_d;
    busy_d      = (state_d != ST_IDLE);
    case (state_d)
      ST_PRE: begin
        sdo_d    = pat_shift_s[0];
        sdo_en_d = 1'b1;
      end
      ST_DATA: begin
        sdo_d    = shift_d[DATA_W-1];
        sdo_en_d = 1'b1;
      end
      default: begin
        sdo_d    = 1'b0;
        sdo_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      shift_q     <= {DATA_W{1'b0}};
      sdo_q       <= 1'b0;
      sdo_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      sdo_q       <= sdo_d;
      sdo_en_q    <= sdo_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign sdo        = sdo_q;
  assign sdo_en     = sdo_en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: each accepted word queues its expected per-cycle frame,
// which is popped and compared against the DUT every cycle.
module tb_seq_pattern_tx;

  localparam int         PAT_W   = 4;
  localparam int         DATA_W  = 8;
  localparam int         GAP     = 2;
  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         FRAME   = PAT_W + DATA_W + GAP;

  typedef struct packed {
    logic sdo;
    logic en;
    logic busy;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, sdo, sdo_en, busy, frame_done;
  logic [7:0] frame_cnt;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         mdl_left = 0;
  logic [7:0] mdl_cnt = 8'd0;
  exp_t       exp_q[$];
  int         acc_cyc[$];
  int         en_cnt  = 0;
  int         det_cnt = 0;
  int         det_st  = 0;

  seq_pattern_tx #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .DATA_W (DATA_W),
    .GAP    (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sdo       (sdo),
    .sdo_en    (sdo_en),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    logic [3:0] p;
    exp_t       e;
    p = PATTERN;
    for (int i = PAT_W - 1; i >= 0; i--) begin
      e = '{sdo: p[i], en: 1'b1, busy: 1'b1, done: 1'b0};
      exp_q.push_back(e);
    end
    for (int i = DATA_W - 1; i >= 0; i--) begin
      e = '{sdo: d[i], en: 1'b1, busy: 1'b1, done: 1'b0};
      exp_q.push_back(e);
    end
    for (int i = 0; i < GAP; i++) begin
      e = '{sdo: 1'b0, en: 1'b0, busy: 1'b1, done: (i == 0)};
      exp_q.push_back(e);
    end
  endtask

  // 1011 Moore non-overlapping detector fed from sdo.
  task automatic det_update(input logic x);
    case (det_st)
      0:       det_st = x ? 1 : 0;
      1:       det_st = x ? 1 : 2;
      2:       det_st = x ? 3 : 0;
      3:       det_st = x ? 4 : 2;
      default: det_st = x ? 1 : 0;
    endcase
    if (det_st == 4) det_cnt++;
  endtask

  task automatic step();
    logic acc;
    exp_t e;
    acc = rst && in_valid && (mdl_left == 0);
    if (rst && in_valid && in_ready) acc_cyc.push_back(cyc);
    @(posedge clk);
    cyc++;
    if (!rst) begin
      exp_q.delete();
      mdl_left = 0;
      mdl_cnt  = 8'd0;
    end else if (acc) begin
      push_frame(in_data);
      mdl_left = FRAME;
    end else if (mdl_left > 0) begin
      mdl_left--;
    end
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (e.done) mdl_cnt++;
    check_val("sdo", 32'(sdo), 32'(e.sdo));
    check_val("sdo_en", 32'(sdo_en), 32'(e.en));
    check_val("busy", 32'(busy), 32'(e.busy));
    check_val("frame_done", 32'(frame_done), 32'(e.done));
    check_val("in_ready", 32'(in_ready), 32'(mdl_left == 0));
    check_val("frame_cnt", 32'(frame_cnt), 32'(mdl_cnt));
    if (sdo_en === 1'b1) en_cnt++;
    det_update(sdo);
  endtask

  initial begin
    int n0;
    logic [7:0] c0;

    // Reset held with in_valid high: nothing may be accepted.
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) step();
    check_val("rst_no_accept", 32'(acc_cyc.size()), 32'd0);

    // Release: accept on first edge, then the A5 frame.
    rst = 1'b1; en_cnt = 0;
    step();
    check_val("accept_after_rst", 32'(acc_cyc.size()), 32'd1);
    in_valid = 1'b0;
    repeat (15) step();
    check_val("en_cycles", 32'(en_cnt), 32'd12);
    check_val("cnt_single", 32'(frame_cnt), 32'd1);

    // Detector loopback.
    det_st = 0; det_cnt = 0;
    in_data = 8'h00; in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (15) step();
    check_val("det_00", 32'(det_cnt), 32'd1);
    det_st = 0; det_cnt = 0;
    in_data = 8'hB0; in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (15) step();
    check_val("det_B0", 32'(det_cnt), 32'd2);

    // Back-to-back with in_valid held high.
    n0 = acc_cyc.size();
    in_data = 8'hFF; in_valid = 1'b1; step();
    in_data = 8'h0F;
    repeat (15) step();
    in_valid = 1'b0;
    repeat (16) step();
    check_val("b2b_count", 32'(acc_cyc.size() - n0), 32'd2);
    if (acc_cyc.size() >= n0 + 2)
      check_val("b2b_spacing", 32'(acc_cyc[n0+1] - acc_cyc[n0]), 32'd15);

    // Word offered mid-frame must be ignored.
    n0 = acc_cyc.size(); c0 = mdl_cnt;
    in_data = 8'h5A; in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (4) step();
    in_data = 8'h3C; in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (12) step();
    check_val("ignore_accepts", 32'(acc_cyc.size() - n0), 32'd1);
    check_val("ignore_cnt", 32'(frame_cnt), 32'(c0 + 8'd1));

    // Abort during DATA on the first frame after reset.
    rst = 1'b0; step(); rst = 1'b1; step();
    in_data = 8'hC3; in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (6) step();
    rst = 1'b0; step(); rst = 1'b1;
    check_val("abort_sdo", 32'(sdo), 32'd0);
    check_val("abort_cnt", 32'(frame_cnt), 32'd0);
    repeat (3) step();

    // 256 frames: counter wraps back to 0.
    for (int f = 0; f < 256; f++) begin
      in_data = 8'($urandom_range(0, 255)); in_valid = 1'b1; step(); in_valid = 1'b0;
      repeat (14) step();
      if (f == 254) check_val("wrap_255", 32'(frame_cnt), 32'd255);
    end
    check_val("wrap_0", 32'(frame_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
